monitor_contador_crescente_decrescente: RTL

Downstream consumer of the up/down counter's `saida` bus. It samples the counter value on every qualified clock edge and classifies each step as up, down, hold or illegal jump. It tracks direction, counts direction reversals, records peak and valley values, and raises a sticky error on any illegal step. It is the self-checking observer wired after the counter in the system and in benches.

---
 rtl/monitor_contador_crescente_decrescente_if.sv | 26 ++
 rtl/monitor_contador_crescente_decrescente.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/monitor_contador_crescente_decrescente_if.sv
// Bus between an up/down counter and its monitor: sampled value and controls in,
// classification results out.
interface monitor_contador_crescente_decrescente_if #(
  parameter int unsigned LARGURA     = 4,
  parameter int unsigned LARGURA_INV = 8
);
  logic [LARGURA-1:0]     entrada;
  logic                   valido;
  logic                   limpa;
  logic [1:0]             sentido;
  logic [LARGURA_INV-1:0] inversoes;
  logic                   erro;
  logic [LARGURA-1:0]     pico;
  logic [LARGURA-1:0]     vale;
  logic                   parado;

  modport master (
    output entrada, valido, limpa,
    input  sentido, inversoes, erro, pico, vale, parado
  );

  modport slave (
    input  entrada, valido, limpa,
    output sentido, inversoes, erro, pico, vale, parado
  );
endinterface

// File: rtl/monitor_contador_crescente_decrescente.sv
// Observer for an up/down counter: classifies each sampled step, tracks direction,
// reversals, peak/valley and a sticky error. MONITOR_CONTADOR_PARADA_EN adds stuck detection.
module monitor_contador_crescente_decrescente #(
  parameter int unsigned LARGURA       = 4,
  parameter int unsigned PERMITE_VOLTA = 0,
  parameter int unsigned LARGURA_INV   = 8
) (
  input logic clock,
  input logic reset,
  monitor_contador_crescente_decrescente_if.slave bus
);

  typedef enum logic [2:0] {StVazio, StInicial, StSubindo, StDescendo, StErro} estado_e;
  typedef enum logic [1:0] {PassoParado, PassoSobe, PassoDesce, PassoSalto} passo_e;

  localparam logic [LARGURA-1:0] MaxValor = '1;

  estado_e                estado_q;
  logic [LARGURA-1:0]     anterior_q;
  logic [LARGURA-1:0]     pico_q;
  logic [LARGURA-1:0]     vale_q;
  logic [1:0]             sentido_q;
  logic [LARGURA_INV-1:0] inversoes_q;
  logic [LARGURA_INV-1:0] inversoes_inc;
  logic                   erro_q;
  logic [LARGURA-1:0]     delta;
  logic                   volta;
  passo_e                 passo;

  always_comb begin
    delta = bus.entrada - anterior_q;
    volta = ((anterior_q == MaxValor) && (bus.entrada == '0)) ||
            ((anterior_q == '0) && (bus.entrada == MaxValor));
    passo = PassoSalto;
    if (delta == '0) begin
      passo = PassoParado;
    end else if ((PERMITE_VOLTA == 0) && volta) begin
      passo = PassoSalto;
    end else if (delta == LARGURA'(1)) begin
      passo = PassoSobe;
    end else if (delta == MaxValor) begin
      passo = PassoDesce;
    end
    inversoes_inc = (inversoes_q == '1) ? inversoes_q : inversoes_q + 1'b1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado_q    <= StVazio;
      anterior_q  <= '0;
      pico_q      <= '0;
      vale_q      <= '1;
      sentido_q   <= 2'b00;
      inversoes_q <= '0;
      erro_q      <= 1'b0;
    end else if (bus.limpa && !bus.valido) begin
      estado_q    <= StVazio;
      anterior_q  <= '0;
      pico_q      <= '0;
      vale_q      <= '1;
      sentido_q   <= 2'b00;
      inversoes_q <= '0;
      erro_q      <= 1'b0;
    end else if (bus.valido) begin
      anterior_q <= bus.entrada;
      if (bus.limpa || (estado_q == StVazio)) begin
        // First sample after reset/clear: only establishes the reference value.
        estado_q    <= StInicial;
        sentido_q   <= 2'b00;
        inversoes_q <= '0;
        erro_q      <= 1'b0;
        pico_q      <= bus.entrada;
        vale_q      <= bus.entrada;
      end else begin
        if (bus.entrada > pico_q) pico_q <= bus.entrada;
        if (bus.entrada < vale_q) vale_q <= bus.entrada;
        if (estado_q != StErro) begin
          unique case (passo)
            PassoSalto: begin
              estado_q  <= StErro;
              sentido_q <= 2'b11;
              erro_q    <= 1'b1;
            end
            PassoSobe: begin
              if (estado_q == StDescendo) inversoes_q <= inversoes_inc;
              estado_q  <= StSubindo;
              sentido_q <= 2'b01;
            end
            PassoDesce: begin
              if (estado_q == StSubindo) inversoes_q <= inversoes_inc;
              estado_q  <= StDescendo;
              sentido_q <= 2'b10;
            end
            default: ;
          endcase
        end
      end
    end
  end

  assign bus.sentido   = sentido_q;
  assign bus.inversoes = inversoes_q;
  assign bus.erro      = erro_q;
  assign bus.pico      = pico_q;
  assign bus.vale      = vale_q;

`ifdef MONITOR_CONTADOR_PARADA_EN
  logic [LARGURA:0] parada_q;
  logic [LARGURA:0] parada_d;
  logic             parado_q;

  // Hold samples count up (saturating); any movement or clear restarts the count.
  always_comb begin
    parada_d = parada_q;
    if (bus.limpa) begin
      parada_d = '0;
    end else if (bus.valido && (estado_q != StVazio)) begin
      if (passo == PassoParado) begin
        if (parada_q != '1) parada_d = parada_q + 1'b1;
      end else begin
        parada_d = '0;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      parada_q <= '0;
      parado_q <= 1'b0;
    end else begin
      parada_q <= parada_d;
      parado_q <= parada_d[LARGURA];
    end
  end

  assign bus.parado = parado_q;
`else
  assign bus.parado = 1'b0;
`endif

endmodule
